// File: rtl/seq_divider_pkg.sv
// +----------------------------------------------------------------------+
// | seq_divider_pkg : state encoding and default width for seq_divider   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_divider_pkg;

  localparam int c_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_up_cntr.sv
// +----------------------------------------------------------------------+
// | up_cntr : WIDTH-bit quotient counter with clear, set-all-ones, +1    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module up_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_set,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // clear wins over set, set wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_set) begin
      r_cnt <= '1;
    end else if (i_inc) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------+
// | seq_divider : unsigned divider by repeated subtraction               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic w_accept;
  logic w_div_zero;
  logic w_ge;
  logic w_clr;
  logic w_set;
  logic w_inc;

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_div_zero = (i_divisor == '0);
  assign w_ge       = (r_rem >= r_div);
  assign w_clr      = w_accept && !w_div_zero;
  assign w_set      = w_accept && w_div_zero;
  assign w_inc      = (r_state == RUN) && w_ge;

  // quotient lives in the counter; it saturates to all-ones on divide-by-zero
  up_cntr #(
    .WIDTH (WIDTH)
  ) u_qcnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_set (w_set),
    .i_inc (w_inc),
    .o_cnt (o_quotient)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rem  <= i_dividend;
            r_div  <= i_divisor;
            r_busy <= 1'b1;
            r_dbz  <= w_div_zero;
            if (w_div_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // subtract only when it cannot wrap; first failing compare ends the run
          if (w_ge) begin
            r_rem <= r_rem - r_div;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_remainder   = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------+
// | tb_seq_divider : directed self-checking bench for seq_divider        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_dividend = '0;
  logic [15:0] i_divisor = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_div_by_zero;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int pulses;

  seq_divider #(
    .WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count edges after the start edge until done is seen (bounded)
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!o_done && n < 70000) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, o_done}, 32'd1);
  endtask

  task automatic launch(input logic [15:0] dvd, input logic [15:0] dvs);
    i_start    = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_q", {16'd0, o_quotient}, 32'd0);
    check("rst_r", {16'd0, o_remainder}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 100 / 7
    launch(16'd100, 16'd7);
    check("t1_busy", {31'd0, o_busy}, 32'd1);
    wait_done("t1", cyc);
    check("t1_cycles", cyc, 32'd15);
    check("t1_q", {16'd0, o_quotient}, 32'd14);
    check("t1_r", {16'd0, o_remainder}, 32'd2);
    check("t1_dbz", {31'd0, o_div_by_zero}, 32'd0);
    tick();
    check("t1_busy_after", {31'd0, o_busy}, 32'd0);
    check("t1_done_once", {31'd0, o_done}, 32'd0);
    tick();
    check("t1_q_hold", {16'd0, o_quotient}, 32'd14);

    // divide by zero
    launch(16'd55, 16'd0);
    wait_done("t2", cyc);
    check("t2_cycles", cyc, 32'd0);
    check("t2_dbz", {31'd0, o_div_by_zero}, 32'd1);
    check("t2_q", {16'd0, o_quotient}, 32'h0000FFFF);
    check("t2_r", {16'd0, o_remainder}, 32'd55);
    tick();
    check("t2_busy_after", {31'd0, o_busy}, 32'd0);
    check("t2_dbz_hold", {31'd0, o_div_by_zero}, 32'd1);

    // dividend smaller than divisor
    launch(16'd3, 16'd9);
    check("t3a_dbz_clr", {31'd0, o_div_by_zero}, 32'd0);
    wait_done("t3a", cyc);
    check("t3a_cycles", cyc, 32'd1);
    check("t3a_q", {16'd0, o_quotient}, 32'd0);
    check("t3a_r", {16'd0, o_remainder}, 32'd3);
    tick();

    // zero dividend
    launch(16'd0, 16'd5);
    wait_done("t3b", cyc);
    check("t3b_cycles", cyc, 32'd1);
    check("t3b_q", {16'd0, o_quotient}, 32'd0);
    check("t3b_r", {16'd0, o_remainder}, 32'd0);
    tick();

    // start while busy is ignored
    launch(16'd200, 16'd10);
    repeat (4) tick();
    i_start    = 1'b1;
    i_dividend = 16'd9;
    i_divisor  = 16'd3;
    tick();
    i_start = 1'b0;
    wait_done("t4", cyc);
    check("t4_cycles", cyc + 5, 32'd21);
    check("t4_q", {16'd0, o_quotient}, 32'd20);
    check("t4_r", {16'd0, o_remainder}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_done) pulses++;
    end
    check("t4_extra_done", pulses, 32'd0);

    // async reset mid-run
    launch(16'd1000, 16'd1);
    repeat (50) tick();
    check("t5_q_mid", {16'd0, o_quotient}, 32'd50);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
    check("t5_rst_q", {16'd0, o_quotient}, 32'd0);
    check("t5_rst_r", {16'd0, o_remainder}, 32'd0);
    check("t5_rst_done", {31'd0, o_done}, 32'd0);
    tick();
    tick();
    check("t5_rst_hold_done", {31'd0, o_done}, 32'd0);
    #3;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_done) pulses++;
    end
    check("t5_no_done", pulses, 32'd0);
    launch(16'd12, 16'd4);
    wait_done("t5b", cyc);
    check("t5b_cycles", cyc, 32'd4);
    check("t5b_q", {16'd0, o_quotient}, 32'd3);
    check("t5b_r", {16'd0, o_remainder}, 32'd0);
    tick();

    // back-to-back with start held high
    i_start    = 1'b1;
    i_dividend = 16'hFFFF;
    i_divisor  = 16'hFFFF;
    tick();
    i_dividend = 16'hFFFF;
    i_divisor  = 16'd1;
    wait_done("t6a", cyc);
    check("t6a_cycles", cyc, 32'd2);
    check("t6a_q", {16'd0, o_quotient}, 32'd1);
    check("t6a_r", {16'd0, o_remainder}, 32'd0);
    tick();
    check("t6_idle_gap", {31'd0, o_busy}, 32'd0);
    tick();
    check("t6b_accepted", {31'd0, o_busy}, 32'd1);
    i_start = 1'b0;
    wait_done("t6b", cyc);
    check("t6b_cycles", cyc, 32'd65536);
    check("t6b_q", {16'd0, o_quotient}, 32'h0000FFFF);
    check("t6b_r", {16'd0, o_remainder}, 32'd0);
    check("t6b_dbz", {31'd0, o_div_by_zero}, 32'd0);
    tick();
    check("t6b_busy_after", {31'd0, o_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Unsigned sequential divider by repeated subtraction; the inverse counterpart of the team's repeated-addition multiplier FSM.
- Loads dividend and divisor on a start pulse, then subtracts the divisor from a remainder register once per cycle while an up-counter counts the quotient.
- Signals completion with a one-cycle done pulse.
- Sits beside the multiplier datapath, sharing the same start/done control style.

Parameters:
WIDTH, 16, bit width of dividend, divisor, quotient and remainder.

Ports:
clk  input  1  rising-edge clock, the only clock in the block.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
dividend  input  WIDTH  unsigned dividend, captured on the accepted start edge.
divisor  input  WIDTH  unsigned divisor, captured on the accepted start edge.
busy  output  1  high from the accepted start edge until the return to IDLE.
done  output  1  one-cycle pulse; results valid.
div_by_zero  output  1  set with done when divisor=0; cleared on the next accepted start.
quotient  output  WIDTH  result quotient.
remainder  output  WIDTH  result remainder.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, internal divisor register=0.
- Reset mid-operation aborts the division with no done pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 is accepted: R<=dividend, D<=divisor, Q<=0, div_by_zero<=0, busy<=1.
  - If divisor=0, next=DONE with div_by_zero<=1, Q<=all-ones, R<=dividend.
  - Otherwise next=RUN.
  - start=0: remain in IDLE, all outputs hold.
- RUN, each cycle:
  - If R>=D: R<=R-D and Q<=Q+1, stay in RUN.
  - Otherwise next=DONE.
  - The compare uses the registered R and D, WIDTH-bit unsigned, with no wrap: the subtraction is performed only when R>=D.
- DONE: done=1 for exactly this one cycle; next=IDLE, busy<=0.
- Latency, normal case:
  - RUN lasts Q+1 cycles: Q subtractions plus one failing compare.
  - done is high in the cycle after edge E0+Q+1.
  - Worst case is dividend=2^WIDTH-1, divisor=1, giving 2^WIDTH cycles.
- Latency, divide-by-zero: done is high in the cycle after edge E0.
- Result holding:
  - quotient and remainder are the final values during the done cycle.
  - They hold until the next accepted start.
  - Values seen while busy=1 are not results and must not be consumed.
- start while busy=1 (RUN or DONE) is ignored, with no queuing.
- start held high continuously: a new division is accepted on the first IDLE edge after done, i.e. back-to-back with one IDLE cycle.
- Dividend < divisor (nonzero): one RUN cycle, then Q=0, R=dividend.
- Dividend = 0, divisor nonzero: Q=0, R=0.
- Quotient counter overflow cannot occur for divisor>=1, because Q <= dividend.

Decomposition:
- Package seq_divider_pkg holds the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2 and the default WIDTH.
- Sub-module up_cntr is the natural split: a WIDTH-bit quotient counter with clr (sync clear to 0), set (load all-ones), inc (+1) and async rst.
- up_cntr is the incrementing mirror of the existing decrementing loadable counter.
- The top level holds the FSM, the R/D registers and the compare/subtract datapath.

Test Plan:
1. Divide 100 by 7: start pulse with dividend=100, divisor=7 -> done after 15 RUN cycles with quotient=14, remainder=2, div_by_zero=0; busy low the cycle after done.
2. Divisor zero: dividend=55, divisor=0 -> done one cycle after the start edge, div_by_zero=1, quotient=16'hFFFF, remainder=55; no RUN cycles.
3. Small or empty dividend:
   - dividend=3, divisor=9 -> quotient=0, remainder=3 after 1 RUN cycle.
   - dividend=0, divisor=5 -> quotient=0, remainder=0.
4. Start while busy: start=1 with 200/10, then re-pulse start with 9/3 mid-RUN -> the second start is ignored; result is quotient=20, remainder=0; done pulses once.
5. Async reset mid-operation: 1000/1 running, assert rst between clock edges at RUN cycle 50 -> outputs go to 0 immediately with no done pulse. After release, 12/4 -> quotient=3, remainder=0.
6. Back-to-back and exact division: start held high with 65535/65535 then 65535/1 -> first result quotient=1, remainder=0. Second start is accepted after one IDLE cycle; its done comes after 65536 RUN cycles with quotient=65535, remainder=0.
